alu_arbiter: RTL and testbench

Shares one 32-bit combinational `alu` between two requesters, e.g. the execute stage (port 0) and the branch/address unit (port 1), using round-robin arbitration. Each port has valid/ready request and response handshakes. The block holds one registered response per port and issues at most one ALU operation per cycle. It sits between the pipeline issue logic and the single ALU instance.

---
 rtl/alu_arb_pkg.sv | 27 ++
 rtl/alu.sv | 55 +++++
 rtl/alu_arbiter_rr.sv | 19 +
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - opcode, flag index and operation types shared by the ALU arbiter
package alu_arb_pkg;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;

  localparam int FLAG_OVF = 2;
  localparam int FLAG_LT  = 1;
  localparam int FLAG_NE  = 0;

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  opcode;
    logic [4:0]  shamt;
  } alu_req_t;

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  flags;
  } alu_rsp_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit combinational ALU decoding opcode[2:0], with {overflow, lt, ne} flags
module alu
  import alu_arb_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  opcode,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        ovf;
  logic        unused_opcode_hi;

  // Upper opcode bits are reserved and never decoded.
  assign unused_opcode_hi = ^opcode[4:3];

  assign sum     = op_a + op_b;
  assign diff    = op_a - op_b;
  assign add_ovf = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
  assign sub_ovf = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (opcode[2:0])
      OP_ADD[2:0]: begin
        result = sum;
        ovf    = add_ovf;
      end
      OP_SUB[2:0]: begin
        result = diff;
        ovf    = sub_ovf;
      end
      OP_AND[2:0]: result = op_a & op_b;
      OP_OR[2:0]:  result = op_a | op_b;
      OP_SLL[2:0]: result = op_a << shamt;
      OP_SRA[2:0]: result = $signed(op_a) >>> shamt;
      default:     result = '0;
    endcase
  end

  always_comb begin
    flags           = '0;
    flags[FLAG_OVF] = ovf;
    flags[FLAG_LT]  = $signed(op_a) < $signed(op_b);
    flags[FLAG_NE]  = op_a != op_b;
  end

endmodule

// File: rtl/alu_arbiter_rr.sv
// rtl/alu_arbiter_rr.sv - combinational two-way round-robin grant (rr_arbiter_2)
module rr_arbiter_2 (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention goes to whichever port did not win last time.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters, one registered response slot per port
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_opA,
  input  logic [31:0] req0_opB,
  input  logic [4:0]  req0_opcode,
  input  logic [4:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_opA,
  input  logic [31:0] req1_opB,
  input  logic [4:0]  req1_opcode,
  input  logic [4:0]  req1_shamt,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic [2:0]  rsp0_flags,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [2:0]  rsp1_flags
);

  alu_req_t       req0;
  alu_req_t       req1;
  alu_req_t       alu_in;
  alu_rsp_t       alu_out;
  logic [1:0]     rsp_ready;
  logic [1:0]     eligible;
  logic [1:0]     grant;
  logic           last_grant_q;
  logic           last_grant_d;
  logic [1:0]     rsp_valid_q;
  logic [1:0]     rsp_valid_d;
  alu_rsp_t [1:0] rsp_data_q;
  alu_rsp_t [1:0] rsp_data_d;

  assign req0      = '{op_a: req0_opA, op_b: req0_opB, opcode: req0_opcode, shamt: req0_shamt};
  assign req1      = '{op_a: req1_opA, op_b: req1_opB, opcode: req1_opcode, shamt: req1_shamt};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A slot that is draining this cycle can be refilled in the same cycle.
  always_comb begin
    eligible    = 2'b00;
    eligible[0] = req0_valid && (!rsp_valid_q[0] || rsp_ready[0]);
    eligible[1] = req1_valid && (!rsp_valid_q[1] || rsp_ready[1]);
  end

  rr_arbiter_2 u_rr (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign req0_ready = grant[0] && reset_n;
  assign req1_ready = grant[1] && reset_n;
  assign alu_in     = grant[1] ? req1 : req0;

  alu u_alu (
    .op_a   (alu_in.op_a),
    .op_b   (alu_in.op_b),
    .opcode (alu_in.opcode),
    .shamt  (alu_in.shamt),
    .result (alu_out.result),
    .flags  (alu_out.flags)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    if (|grant) begin
      last_grant_d = grant[1];
    end
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < 2; i++) begin
      rsp_valid_d[i] = grant[i] | (rsp_valid_q[i] & ~rsp_ready[i]);
      if (grant[i]) begin
        rsp_data_d[i] = alu_out;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= ~FIRST_PRIO;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = rsp_data_q[0].result;
  assign rsp1_result = rsp_data_q[1].result;
  assign rsp0_flags  = rsp_data_q[0].flags;
  assign rsp1_flags  = rsp_data_q[1].flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam bit FP = 1'b0;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        v  [2];
  logic [31:0] a  [2];
  logic [31:0] b  [2];
  logic [4:0]  op [2];
  logic [4:0]  sh [2];
  logic        rr [2];

  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_opA, req0_opB, req1_opA, req1_opB;
  logic [4:0]  req0_opcode, req1_opcode, req0_shamt, req1_shamt;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [2:0]  rsp0_flags, rsp1_flags;

  assign req0_valid  = v[0];
  assign req1_valid  = v[1];
  assign req0_opA    = a[0];
  assign req1_opA    = a[1];
  assign req0_opB    = b[0];
  assign req1_opB    = b[1];
  assign req0_opcode = op[0];
  assign req1_opcode = op[1];
  assign req0_shamt  = sh[0];
  assign req1_shamt  = sh[1];
  assign rsp0_ready  = rr[0];
  assign rsp1_ready  = rr[1];

  always #5 clock = ~clock;

  alu_arbiter #(.FIRST_PRIO(FP)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_opA    (req0_opA),
    .req0_opB    (req0_opB),
    .req0_opcode (req0_opcode),
    .req0_shamt  (req0_shamt),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_opA    (req1_opA),
    .req1_opB    (req1_opB),
    .req1_opcode (req1_opcode),
    .req1_shamt  (req1_shamt),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_flags  (rsp0_flags),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_flags  (rsp1_flags)
  );

  int checks = 0;
  int errors = 0;

  // Model state: one slot per port plus who won the last grant.
  bit          mv    [2];
  logic [31:0] mres  [2];
  logic [2:0]  mflg  [2];
  bit          mfchk [2];
  bit          mlast;
  bit          acc   [2];

  function automatic logic [31:0] ref_result(logic [31:0] x, logic [31:0] y, logic [4:0] o, logic [4:0] s);
    int sx;
    sx = x;
    case (o[2:0])
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x << s;
      3'd5:    return sx >>> s;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(logic [31:0] x, logic [31:0] y, logic [4:0] o);
    longint lx, ly, r;
    bit ovf;
    lx  = longint'($signed(x));
    ly  = longint'($signed(y));
    r   = (o[2:0] == 3'd0) ? lx + ly : lx - ly;
    ovf = (r != longint'(int'(r)));
    return {ovf, lx < ly, x != y};
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i]   = 1'b0;
      mres[i] = '0;
      mflg[i] = '0;
      acc[i]  = 1'b0;
    end
    mlast = !FP;
  endtask

  task automatic set_req(input int p, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] o, input logic [4:0] s);
    v[p]  = 1'b1;
    a[p]  = x;
    b[p]  = y;
    op[p] = o;
    sh[p] = s;
  endtask

  task automatic cycle();
    bit e [2];
    int g;
    @(negedge clock);
    for (int i = 0; i < 2; i++) e[i] = v[i] && (!mv[i] || rr[i]);
    g = -1;
    if (e[0] && e[1]) g = mlast ? 0 : 1;
    else if (e[0]) g = 0;
    else if (e[1]) g = 1;
    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      acc[i] = (g == i);
      if (g == i) begin
        mv[i]    = 1'b1;
        mres[i]  = ref_result(a[i], b[i], op[i], sh[i]);
        mflg[i]  = ref_flags(a[i], b[i], op[i]);
        mfchk[i] = (op[i][2:1] == 2'b00);
      end else if (rr[i]) begin
        mv[i] = 1'b0;
      end
    end
    if (g >= 0) mlast = (g == 1);
    chk("rsp0_valid", rsp0_valid, mv[0]);
    chk("rsp1_valid", rsp1_valid, mv[1]);
    if (mv[0]) chk("rsp0_result", rsp0_result, mres[0]);
    if (mv[1]) chk("rsp1_result", rsp1_result, mres[1]);
    if (mv[0] && mfchk[0]) chk("rsp0_flags", rsp0_flags, mflg[0]);
    if (mv[1] && mfchk[1]) chk("rsp1_flags", rsp1_flags, mflg[1]);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 32'd1, 32'd2, OP_ADD, 5'd0);
      rr[i] = 1'b1;
    end
    model_reset();

    // Reset state, with both requests present.
    #3;
    chk("reset_req0_ready", req0_ready, 1'b0);
    chk("reset_req1_ready", req1_ready, 1'b0);
    chk("reset_rsp0_valid", rsp0_valid, 1'b0);
    chk("reset_rsp1_valid", rsp1_valid, 1'b0);
    chk("reset_rsp0_result", rsp0_result, 32'd0);
    chk("reset_rsp1_result", rsp1_result, 32'd0);
    chk("reset_rsp0_flags", rsp0_flags, 3'd0);
    chk("reset_rsp1_flags", rsp1_flags, 3'd0);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Both ports contend for 4 cycles: grants alternate starting with FIRST_PRIO.
    set_req(0, 32'd10, 32'd20, OP_ADD, 5'd0);
    set_req(1, 32'd3, 32'd5, OP_SUB, 5'd0);
    cycle();
    chk("alt_first_grant_port0", rsp0_result, 32'd30);
    cycle();
    chk("sub_result", rsp1_result, 32'hFFFF_FFFE);
    chk("sub_flags", rsp1_flags, 3'b011);
    cycle();
    cycle();

    // Slot 1 full and stalled: port 0 wins every cycle, slot 1 data holds.
    rr[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 32'd100 + k, 32'd1, OP_OR, 5'd0);
      cycle();
    end
    chk("stalled_rsp1_result", rsp1_result, 32'hFFFF_FFFE);
    rr[1] = 1'b1;
    cycle();
    v[1] = 1'b0;

    // Single-port ADD.
    set_req(0, 32'd7, 32'd5, OP_ADD, 5'd0);
    cycle();
    chk("add_result", rsp0_result, 32'd12);
    chk("add_flags", rsp0_flags, 3'b001);

    // Signed overflow and arithmetic shift.
    set_req(0, 32'h7FFF_FFFF, 32'd1, OP_ADD, 5'd0);
    cycle();
    chk("ovf_result", rsp0_result, 32'h8000_0000);
    chk("ovf_flags", rsp0_flags, 3'b101);
    set_req(0, 32'h8000_0000, 32'd0, OP_SRA, 5'd4);
    cycle();
    chk("sra_result", rsp0_result, 32'hF800_0000);

    // Fill and drain in the same cycle, three back-to-back ops.
    set_req(0, 32'hF0F0_1234, 32'h0FF0_FFFF, OP_AND, 5'd0);
    cycle();
    chk("b2b_valid_0", rsp0_valid, 1'b1);
    set_req(0, 32'h0000_0003, 32'd0, OP_SLL, 5'd31);
    cycle();
    chk("b2b_valid_1", rsp0_valid, 1'b1);
    set_req(0, 32'd50, 32'd8, OP_SUB, 5'd0);
    cycle();
    chk("b2b_valid_2", rsp0_valid, 1'b1);
    chk("b2b_result_2", rsp0_result, 32'd42);

    // Randomized traffic; unaccepted requests are held stable.
    v[0] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] || acc[i]) begin
          v[i]  = ($urandom_range(0, 3) != 0);
          a[i]  = rand_operand();
          b[i]  = rand_operand();
          op[i] = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 5))};
          sh[i] = 5'($urandom);
        end
        rr[i] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end

    // Fill both slots, then reset mid-cycle.
    for (int i = 0; i < 2; i++) begin
      set_req(i, 32'd9 + i, 32'd4, OP_ADD, 5'd0);
      rr[i] = 1'b0;
    end
    cycle();
    cycle();
    chk("pre_reset_rsp0_valid", rsp0_valid, 1'b1);
    chk("pre_reset_rsp1_valid", rsp1_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rsp0_valid", rsp0_valid, 1'b0);
    chk("async_rsp1_valid", rsp1_valid, 1'b0);
    chk("async_rsp0_result", rsp0_result, 32'd0);
    chk("async_req0_ready", req0_ready, 1'b0);
    chk("async_req1_ready", req1_ready, 1'b0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    rr[0] = 1'b1;
    rr[1] = 1'b1;
    cycle();
    chk("post_reset_winner_result", rsp0_result, 32'd13);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
